aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Sequences one iterative AES round datapath (state register + round logic) for one 128-bit block at a time.
//  Sits between the top-level AES controller and the round datapath and key store.
//  Issues the round-key index and the load/round strobes, and returns the result over a valid/ready handshake.
//  Arbitrates key changes against block traffic: a key change never interrupts an in-flight block.
// PARAMETERS
//  NUM_ROUNDS  10  AES rounds; legal values 10/12/14; other values are a compile-time $error
//  RK_W        derived localparam = $clog2(NUM_ROUNDS+1); round-key index width; not overridable
// PORTS
//  clk           in   1     system clock; all logic on posedge
//  n_rst         in   1     reset: synchronous, active-low
//  blk_valid     in   1     upstream has a block ready for the datapath
//  blk_ready     out  1     block accepted this cycle (blk_valid & blk_ready)
//  enc_dec       in   1     0 = encrypt, 1 = decrypt; sampled on accept
//  chg_key_req   in   1     request to expand a new key (level; sticky-captured)
//  key_load      out  1     1-cycle pulse to key expander: start expansion
//  chg_key_done  in   1     key expander finished; key store valid
//  rk_req        out  1     requesting round key rk_index from key store
//  rk_index      out  RK_W  round-key index requested
//  rk_valid      in   1     key store presents rk_index this cycle
//  state_load    out  1     load input block XOR round key into state register
//  round_en      out  1     datapath performs one round this cycle
//  last_round    out  1     qualifies round_en: skip (Inv)MixColumns
//  dec_mode      out  1     latched direction of the in-flight block
//  out_valid     out  1     state register holds a finished block
//  out_ready     in   1     downstream takes the block
//  busy          out  1     state != IDLE
// BEHAVIOUR
//  Reset (n_rst==0 at posedge): state=IDLE, round ctr=0, key_pend=0, dec_mode=0; all outputs 0.
//  Reset mid-operation aborts the block without emitting out_valid.
//  Outputs are decoded from state; rk-dependent strobes are additionally gated by rk_valid.
//  key_pend: set when chg_key_req=1 in any state other than KEY_CHG; cleared on entry to KEY_CHG.
//  IDLE:     key_pend|chg_key_req -> KEY_CHG; key_load=1 this cycle. Key change beats blk_valid.
//            Otherwise blk_ready=blk_valid. On accept: latch dec_mode=enc_dec -> PRE_ADD.
//  KEY_CHG:  blk_ready=0; wait chg_key_done -> IDLE. chg_key_done in other states is ignored.
//  PRE_ADD:  rk_req=1; rk_index = dec ? NUM_ROUNDS : 0.
//            On rk_valid: state_load=1, ctr<=1 -> ROUND; else hold.
//  ROUND:    rk_req=1; rk_index = dec ? NUM_ROUNDS-ctr : ctr.
//            On rk_valid: round_en=1. If ctr==NUM_ROUNDS-1 -> FINAL; else ctr++.
//  FINAL:    rk_req=1; rk_index = dec ? 0 : NUM_ROUNDS.
//            On rk_valid: round_en=1, last_round=1 -> HOLD.
//  HOLD:     out_valid=1, datapath frozen. On out_ready -> IDLE.
//            out_valid stays high and stable until taken. No accept in the same cycle (blk_ready=0).
//  rk_valid while rk_req=0 is ignored. rk_valid low stalls the sequence indefinitely with no output change.
//  Latency with rk_valid tied 1, accept at cycle T:
//    state_load at T+1; round_en at T+2..T+NUM_ROUNDS+1; out_valid from T+NUM_ROUNDS+2.
//    Throughput is one block per NUM_ROUNDS+3 cycles.
//  ctr width RK_W; it never wraps, since the max value reached is NUM_ROUNDS-1.
// STRUCTURE
//  aes_pkg: seq_state_t enum {IDLE, KEY_CHG, PRE_ADD, ROUND, FINAL, HOLD}; AES_ENC=1'b0, AES_DEC=1'b1.
//  One sub-module: aes_round_ctr, a sync-active-low-reset up-counter with load-1 and enable.
//  All other logic is inline: a single next-state always_comb and a single output decode always_comb.
// TESTING
//  1 Enc, NUM_ROUNDS=10, rk_valid=1, accept at T:
//    state_load@T+1; rk_index 1..9 on ROUND; round_en@T+2..T+11; last_round only @T+11; out_valid@T+12.
//  2 Dec, same setup:
//    rk_index sequence 10,9,...,1,0; dec_mode=1 throughout; last_round with rk_index=0.
//  3 chg_key_req=1 and blk_valid=1 in IDLE, same cycle:
//    key_load pulse, blk_ready=0; block accepted 1 cycle after chg_key_done.
//  4 chg_key_req pulsed during ROUND:
//    block completes; after out_ready, IDLE goes straight to KEY_CHG (no new accept).
//  5 rk_valid toggled 1010.. and out_ready held 0 for 5 cycles:
//    round_en only on rk_valid=1 cycles, 10 in total; out_valid stays high and stable for 5 cycles.
//  6 n_rst=0 for 1 cycle while in ROUND with ctr=5:
//    next cycle all outputs 0, busy=0; a fresh block then runs the full test-1 timing.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types for the AES round sequencer.
//   seq_state_t : sequencer FSM states
//   AES_ENC/DEC : encoding of the enc_dec / dec_mode direction bit
package aes_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StKeyChg,
    StPreAdd,
    StRound,
    StFinal,
    StHold
  } seq_state_t;

  localparam logic AES_ENC = 1'b0;
  localparam logic AES_DEC = 1'b1;

endpackage

// File: rtl/aes_round_ctr.sv
// Round counter for the AES round sequencer.
//   clk, n_rst : clock, synchronous active-low reset (count -> 0)
//   load_one   : force the count to 1 (first full round after the pre-add)
//   inc        : advance the count by one; load_one has priority
//   count      : current round number
module aes_round_ctr #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load_one,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_one) begin
      count_d = Width'(1);
    end else if (inc) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/aes_round_sequencer.sv
// Sequencer for an iterative AES round datapath, one 128-bit block at a time.
// Requests round keys in encrypt or decrypt order, strobes the pre-add / round / last round,
// returns the finished block over out_valid/out_ready and slots key changes between blocks.
//   clk, n_rst              : clock, synchronous active-low reset
//   blk_valid / blk_ready   : block intake handshake; enc_dec sampled on accept
//   chg_key_req / key_load  : key change request (captured) / start pulse to the expander
//   chg_key_done            : expander finished
//   rk_req, rk_index        : round-key request and index to the key store
//   rk_valid                : key store presents the requested key this cycle
//   state_load, round_en    : datapath strobes; last_round qualifies round_en
//   dec_mode                : direction of the in-flight block
//   out_valid / out_ready   : result handshake
//   busy                    : sequencer not idle
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter  int unsigned NUM_ROUNDS = 10,
  localparam int unsigned RK_W       = $clog2(NUM_ROUNDS + 1)
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            blk_valid,
  output logic            blk_ready,
  input  logic            enc_dec,
  input  logic            chg_key_req,
  output logic            key_load,
  input  logic            chg_key_done,
  output logic            rk_req,
  output logic [RK_W-1:0] rk_index,
  input  logic            rk_valid,
  output logic            state_load,
  output logic            round_en,
  output logic            last_round,
  output logic            dec_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_num_rounds
    $error("aes_round_sequencer: NUM_ROUNDS must be 10, 12 or 14");
  end

  localparam logic [RK_W-1:0] NrIdx   = RK_W'(NUM_ROUNDS);
  localparam logic [RK_W-1:0] LastCtr = RK_W'(NUM_ROUNDS - 1);

  seq_state_t      state_q, state_d;
  logic            key_pend_q, key_pend_d;
  logic            dec_mode_q, dec_mode_d;
  logic            ctr_load, ctr_inc;
  logic [RK_W-1:0] ctr;

  aes_round_ctr #(
    .Width (RK_W)
  ) u_round_ctr (
    .clk      (clk),
    .n_rst    (n_rst),
    .load_one (ctr_load),
    .inc      (ctr_inc),
    .count    (ctr)
  );

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    dec_mode_d = dec_mode_q;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
    case (state_q)
      StIdle: begin
        // A pending or fresh key change wins over a waiting block.
        if (key_pend_q || chg_key_req) begin
          state_d = StKeyChg;
        end else if (blk_valid) begin
          dec_mode_d = enc_dec;
          state_d    = StPreAdd;
        end
      end
      StKeyChg: begin
        if (chg_key_done) state_d = StIdle;
      end
      StPreAdd: begin
        if (rk_valid) begin
          ctr_load = 1'b1;
          state_d  = StRound;
        end
      end
      StRound: begin
        if (rk_valid) begin
          if (ctr == LastCtr) begin
            state_d = StFinal;
          end else begin
            ctr_inc = 1'b1;
          end
        end
      end
      StFinal: begin
        if (rk_valid) state_d = StHold;
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Requests seen mid-block are remembered; entering KEY_CHG consumes them.
    key_pend_d = key_pend_q;
    if ((state_d == StKeyChg) && (state_q != StKeyChg)) begin
      key_pend_d = 1'b0;
    end else if (chg_key_req && (state_q != StKeyChg)) begin
      key_pend_d = 1'b1;
    end
  end

  // Output decode.
  always_comb begin
    blk_ready  = 1'b0;
    key_load   = 1'b0;
    rk_req     = 1'b0;
    rk_index   = '0;
    state_load = 1'b0;
    round_en   = 1'b0;
    last_round = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      StIdle: begin
        if (key_pend_q || chg_key_req) begin
          key_load = 1'b1;
        end else begin
          blk_ready = blk_valid;
        end
      end
      StPreAdd: begin
        rk_req     = 1'b1;
        rk_index   = dec_mode_q ? NrIdx : '0;
        state_load = rk_valid;
      end
      StRound: begin
        rk_req   = 1'b1;
        rk_index = dec_mode_q ? (NrIdx - ctr) : ctr;
        round_en = rk_valid;
      end
      StFinal: begin
        rk_req     = 1'b1;
        rk_index   = dec_mode_q ? '0 : NrIdx;
        round_en   = rk_valid;
        last_round = rk_valid;
      end
      StHold: begin
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign dec_mode = dec_mode_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      key_pend_q <= 1'b0;
      dec_mode_q <= AES_ENC;
    end else begin
      state_q    <= state_d;
      key_pend_q <= key_pend_d;
      dec_mode_q <= dec_mode_d;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer (NUM_ROUNDS = 10).
// Expected outputs come from a block-level model: a block walks key steps 0..N, each step
// consuming one rk_valid cycle (step s uses key s for encrypt, N-s for decrypt), then holds
// its result until out_ready.
module tb_aes_round_sequencer;

  localparam int unsigned N   = 10;
  localparam int unsigned RKW = $clog2(N + 1);

  typedef logic [RKW+8:0] ovec_t;

  logic           clk = 1'b0;
  logic           n_rst, blk_valid, enc_dec, chg_key_req, chg_key_done, rk_valid, out_ready;
  logic           blk_ready, key_load, rk_req, state_load, round_en, last_round;
  logic           dec_mode, out_valid, busy;
  logic [RKW-1:0] rk_index;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic last_dm = 1'b0;

  always #5 clk = ~clk;

  aes_round_sequencer #(
    .NUM_ROUNDS (N)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .enc_dec      (enc_dec),
    .chg_key_req  (chg_key_req),
    .key_load     (key_load),
    .chg_key_done (chg_key_done),
    .rk_req       (rk_req),
    .rk_index     (rk_index),
    .rk_valid     (rk_valid),
    .state_load   (state_load),
    .round_en     (round_en),
    .last_round   (last_round),
    .dec_mode     (dec_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  function automatic ovec_t mk(input logic br, kl, rq, input logic [RKW-1:0] idx,
                               input logic sl, re, lr, dm, ov, bz);
    return {br, kl, rq, idx, sl, re, lr, dm, ov, bz};
  endfunction

  function automatic ovec_t obs();
    return {blk_ready, key_load, rk_req, rk_index, state_load, round_en, last_round,
            dec_mode, out_valid, busy};
  endfunction

  // Runs one block from accept (DUT must be idle, no key pending). rk_mode: 0 = rk_valid high,
  // 1 = toggling 1010.., 2 = random. key_cyc pulses chg_key_req on that cycle after accept;
  // abort_cyc asserts reset on that cycle and ends the block there.
  task automatic run_block(input logic dec, input int rk_mode, input int hold_cycles,
                           input int key_cyc, input int abort_cyc, input string tag,
                           output int cycles);
    ovec_t exp_v, got_v;
    int    pos, hold, rounds, cyc;
    logic  rv;
    bit    done;
    pos = 0; hold = 0; rounds = 0; cyc = 0; done = 0;
    blk_valid    = 1'b1;
    enc_dec      = dec;
    chg_key_req  = 1'b0;
    chg_key_done = 1'b0;
    rk_valid     = 1'($urandom);
    out_ready    = 1'($urandom);
    #3;
    exp_v = mk(1, 0, 0, '0, 0, 0, 0, last_dm, 0, 0);
    got_v = obs();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s accept: got %b want %b", tag, got_v, exp_v);
    end
    @(posedge clk); #1;
    blk_valid = 1'b0;
    enc_dec   = 1'($urandom);
    while (!done) begin
      case (rk_mode)
        0:       rv = 1'b1;
        1:       rv = (cyc % 2 == 0);
        default: rv = 1'($urandom);
      endcase
      rk_valid     = rv;
      chg_key_req  = (cyc == key_cyc);
      chg_key_done = 1'($urandom);
      out_ready    = (pos == N + 1) ? (hold >= hold_cycles) : 1'($urandom);
      #3;
      if (pos <= N) begin
        exp_v = mk(0, 0, 1, dec ? RKW'(N - pos) : RKW'(pos), rv && pos == 0, rv && pos > 0,
                   rv && pos == N, dec, 0, 1);
      end else begin
        exp_v = mk(0, 0, 0, '0, 0, 0, 0, dec, 1, 1);
      end
      got_v = obs();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s cyc %0d: got %b want %b", tag, cyc, got_v, exp_v);
      end
      rounds += int'(round_en);
      if (cyc == abort_cyc) begin
        n_rst = 1'b0;
        done  = 1;
      end else if (pos <= N) begin
        if (rv) pos++;
      end else if (out_ready) begin
        done = 1;
      end else begin
        hold++;
      end
      cyc++;
      if (cyc > 4000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s timeout: got cyc %0d want <= 4000", tag, cyc);
        done = 1;
      end
      @(posedge clk); #1;
    end
    cycles       = cyc + 1;
    chg_key_req  = 1'b0;
    chg_key_done = 1'b0;
    out_ready    = 1'b0;
    rk_valid     = 1'b0;
    if (abort_cyc < 0) begin
      n_cmp++;
      if (rounds != N) begin
        n_bad++;
        $display("FAIL %s round count: got %0d want %0d", tag, rounds, N);
      end
      last_dm = dec;
    end
  endtask

  task automatic check_idle(input string tag);
    ovec_t exp_v, got_v;
    #3;
    exp_v = mk(0, 0, 0, '0, 0, 0, 0, last_dm, 0, 0);
    got_v = obs();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, got_v, exp_v);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; blk_valid = 1'b1; enc_dec = 1'b1; chg_key_req = 1'b1;
    chg_key_done = 1'b0; rk_valid = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1; blk_valid = 1'b0; chg_key_req = 1'b0;
    last_dm = 1'b0;
    check_idle("reset_state");
    @(posedge clk); #1;
    check_idle("reset_idle2");
  endtask

  task automatic test_enc_timing();
    int cyc;
    run_block(1'b0, 0, 0, -1, -1, "enc", cyc);
    n_cmp++;
    if (cyc != N + 3) begin
      n_bad++;
      $display("FAIL enc_period: got %0d want %0d", cyc, N + 3);
    end
  endtask

  task automatic test_dec_timing();
    int cyc;
    run_block(1'b1, 0, 0, -1, -1, "dec", cyc);
  endtask

  task automatic test_key_vs_block();
    ovec_t exp_v, got_v;
    int    cyc;
    blk_valid = 1'b1; enc_dec = 1'b1; chg_key_req = 1'b1;
    #3;
    exp_v = mk(0, 1, 0, '0, 0, 0, 0, last_dm, 0, 0);
    got_v = obs();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL key_first: got %b want %b", got_v, exp_v);
    end
    @(posedge clk); #1;
    chg_key_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chg_key_done = (i == 3);
      #3;
      exp_v = mk(0, 0, 0, '0, 0, 0, 0, last_dm, 0, 1);
      got_v = obs();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL key_wait %0d: got %b want %b", i, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    chg_key_done = 1'b0;
    run_block(1'b1, 0, 0, -1, -1, "after_key", cyc);
  endtask

  task automatic test_key_during_block();
    ovec_t exp_v, got_v;
    int    cyc;
    run_block(1'($urandom), 0, 2, 4, -1, "key_mid", cyc);
    blk_valid = 1'b1;
    #3;
    exp_v = mk(0, 1, 0, '0, 0, 0, 0, last_dm, 0, 0);
    got_v = obs();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL key_pend_load: got %b want %b", got_v, exp_v);
    end
    @(posedge clk); #1;
    chg_key_done = 1'b1;
    #3;
    exp_v = mk(0, 0, 0, '0, 0, 0, 0, last_dm, 0, 1);
    got_v = obs();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL key_pend_chg: got %b want %b", got_v, exp_v);
    end
    @(posedge clk); #1;
    blk_valid = 1'b0; chg_key_done = 1'b0;
    check_idle("key_pend_cleared");
    @(posedge clk); #1;
  endtask

  task automatic test_rk_toggle();
    int cyc;
    run_block(1'b0, 1, 5, -1, -1, "toggle_enc", cyc);
    run_block(1'b1, 1, 5, -1, -1, "toggle_dec", cyc);
  endtask

  task automatic test_reset_mid();
    int cyc;
    run_block(1'($urandom), 0, 0, -1, 5, "reset_mid", cyc);
    n_rst = 1'b1; rk_valid = 1'b1;
    last_dm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle("post_abort");
      @(posedge clk); #1;
    end
    run_block(1'b0, 0, 0, -1, -1, "fresh", cyc);
    n_cmp++;
    if (cyc != N + 3) begin
      n_bad++;
      $display("FAIL fresh_period: got %0d want %0d", cyc, N + 3);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int i = 0; i < 3; i++) begin
      run_block(1'(i % 2), 0, 0, -1, -1, "b2b", cyc);
      n_cmp++;
      if (cyc != N + 3) begin
        n_bad++;
        $display("FAIL b2b_period %0d: got %0d want %0d", i, cyc, N + 3);
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int i = 0; i < 8; i++) begin
      run_block(1'($urandom), 2, int'($urandom_range(0, 3)), -1, -1, "random", cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_enc_timing();
    test_dec_timing();
    test_key_vs_block();
    test_key_during_block();
    test_rk_toggle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
